// File: rtl/quad_enc_pwm_array.sv
// NUM_CH channels, each with an x4 quadrature decoder, a position counter and a PWM generator with shadowed period/duty.
// Optional feature macro: QUAD_ENC_GLITCH_FILTER_EN adds a 3-sample stability filter on each synchronised encoder bit.
module quad_enc_pwm_array #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int PWM_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [2*NUM_CH-1:0]       encoder_in_new_signal,
  output logic [NUM_CH-1:0]         pwm_out_new_signal,
  input  logic [$clog2(NUM_CH)+1:0] avs_address,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  input  logic                      avs_read,
  output logic [31:0]               avs_readdata
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic [AW-1:0]    ch_sel;
  logic [1:0]       reg_sel;
  logic [CNT_W-1:0] pos_all [NUM_CH];
  logic [PWM_W-1:0] per_all [NUM_CH];
  logic [PWM_W-1:0] duty_all [NUM_CH];
  logic [NUM_CH-1:0] err_all;
  logic [NUM_CH-1:0] dir_all;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign ch_sel    = avs_address >> 2;
  assign reg_sel   = avs_address[1:0];
  assign unused_wd = ^avs_writedata;

  // Position of an {A,B} pair along the forward sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b10:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       sync_p [SYNC_STAGES];
    logic [1:0]       prev_p;
    logic [1:0]       cur_ab;
    logic [1:0]       delta;
    logic             up, dn, illegal, wr_hit;
    logic [CNT_W-1:0] pos_q;
    logic             err_q, dir_q;
    logic [PWM_W-1:0] per_sh, duty_sh, per_act, duty_act, pwm_cnt;
    logic             pwm_q, wrap;

    assign wr_hit = avs_write && (ch_sel == AW'(i));

`ifdef QUAD_ENC_GLITCH_FILTER_EN
    logic [1:0] hist1_p, hist2_p, raw;
    assign raw = sync_p[SYNC_STAGES-1];
    // A bit is accepted only after three identical samples; otherwise it holds its last accepted value.
    always_comb begin
      cur_ab = prev_p;
      for (int b = 0; b < 2; b++)
        if (raw[b] == hist1_p[b] && raw[b] == hist2_p[b]) cur_ab[b] = raw[b];
    end
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        hist1_p <= '0;
        hist2_p <= '0;
      end else begin
        hist1_p <= raw;
        hist2_p <= hist1_p;
      end
    end
`else
    assign cur_ab = sync_p[SYNC_STAGES-1];
`endif

    assign delta   = gray_idx(cur_ab) - gray_idx(prev_p);
    assign up      = (delta == 2'd1);
    assign dn      = (delta == 2'd3);
    assign illegal = (delta == 2'd2);

    // Synchroniser stages, then the previous-state register used by the decoder
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
        prev_p <= '0;
      end else begin
        sync_p[0] <= {encoder_in_new_signal[2*i], encoder_in_new_signal[2*i+1]};
        for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
        prev_p <= cur_ab;
      end
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        pos_q <= '0;
        err_q <= 1'b0;
        dir_q <= 1'b0;
      end else begin
        if (wr_hit && reg_sel == 2'd0) pos_q <= avs_writedata[CNT_W-1:0];
        else if (up)                   pos_q <= pos_q + CNT_W'(1);
        else if (dn)                   pos_q <= pos_q - CNT_W'(1);
        if (up)      dir_q <= 1'b1;
        else if (dn) dir_q <= 1'b0;
        if (illegal)                                      err_q <= 1'b1;
        else if (wr_hit && reg_sel == 2'd1 && avs_writedata[0]) err_q <= 1'b0;
      end
    end

    // PWM: shadow registers are copied into the active set only on the wrap cycle
    assign wrap = (pwm_cnt >= per_act);
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        per_sh   <= '1;
        duty_sh  <= '0;
        per_act  <= '1;
        duty_act <= '0;
        pwm_cnt  <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (wr_hit && reg_sel == 2'd2) per_sh  <= avs_writedata[PWM_W-1:0];
        if (wr_hit && reg_sel == 2'd3) duty_sh <= avs_writedata[PWM_W-1:0];
        pwm_q <= (pwm_cnt < duty_act);
        if (wrap) begin
          pwm_cnt  <= '0;
          per_act  <= per_sh;
          duty_act <= duty_sh;
        end else begin
          pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
      end
    end

    assign pos_all[i]            = pos_q;
    assign err_all[i]            = err_q;
    assign dir_all[i]            = dir_q;
    assign per_all[i]            = per_sh;
    assign duty_all[i]           = duty_sh;
    assign pwm_out_new_signal[i] = pwm_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          2'd0:    rd_mux = 32'(pos_all[i]);
          2'd1:    rd_mux = {30'd0, dir_all[i], err_all[i]};
          2'd2:    rd_mux = 32'(per_all[i]);
          default: rd_mux = 32'(duty_all[i]);
        endcase
      end
    end
  end

  // Read data stage: captured on a read strobe, held until the next one
  always_ff @(posedge clk_clk) begin
    if (reset_reset)   avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_quad_enc_pwm_array.sv
// Scoreboard bench for quad_enc_pwm_array: reads are checked by a monitor against a behavioural encoder/PWM model.
module tb_quad_enc_pwm_array;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int PWM_W  = 10;
  localparam int SS     = 2;
`ifdef QUAD_ENC_GLITCH_FILTER_EN
  localparam int LAT = SS + 3;
`else
  localparam int LAT = SS + 1;
`endif
  localparam int SETTLE = LAT + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*NUM_CH-1:0] enc;
  logic [NUM_CH-1:0] pwm;
  logic [2:0]        addr;
  logic              wr, rd;
  logic [31:0]       wdata, rdata;

  quad_enc_pwm_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .SYNC_STAGES(SS)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .encoder_in_new_signal(enc),
    .pwm_out_new_signal(pwm), .avs_address(addr), .avs_write(wr),
    .avs_writedata(wdata), .avs_read(rd), .avs_readdata(rdata)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        rd_seen = 1'b0;
  logic [31:0] mon_e;
  string       mon_n;

  // Behavioural model: position as an integer mod 2^16, quadrature phase from the forward sequence
  int         m_pos  [NUM_CH];
  logic       m_err  [NUM_CH];
  logic       m_dir  [NUM_CH];
  logic [1:0] m_ab   [NUM_CH];
  int         m_per  [NUM_CH];
  int         m_duty [NUM_CH];
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic int quarter(input logic [1:0] ab);
    for (int k = 0; k < 4; k++) if (seq[k] == ab) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_err[c] = 1'b0; m_dir[c] = 1'b0; m_ab[c] = 2'b00;
      m_per[c] = 1023; m_duty[c] = 0;
    end
  endtask

  task automatic set_pins(input int ch, input logic [1:0] ab);
    int d;
    d = (quarter(ab) - quarter(m_ab[ch]) + 4) % 4;
    if (d == 1) begin m_pos[ch] = (m_pos[ch] + 1) % 65536; m_dir[ch] = 1'b1; end
    else if (d == 3) begin m_pos[ch] = (m_pos[ch] + 65535) % 65536; m_dir[ch] = 1'b0; end
    else if (d == 2) m_err[ch] = 1'b1;
    m_ab[ch] = ab;
    enc[2*ch]   = ab[1];
    enc[2*ch+1] = ab[0];
  endtask

  task automatic step(input int ch, input bit fwd);
    set_pins(ch, seq[(quarter(m_ab[ch]) + (fwd ? 1 : 3)) % 4]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] data);
    addr = 3'(ch * 4 + r); wdata = data; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    case (r)
      0: m_pos[ch] = int'(data[15:0]);
      1: if (data[0]) m_err[ch] = 1'b0;
      2: m_per[ch] = int'(data[9:0]);
      default: m_duty[ch] = int'(data[9:0]);
    endcase
  endtask

  task automatic bus_read(input int ch, input int r, input logic [31:0] expv, input string nm);
    exp_q.push_back(expv); name_q.push_back(nm);
    addr = 3'(ch * 4 + r); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic read_model(input int ch);
    bus_read(ch, 0, 32'(m_pos[ch]), $sformatf("ch%0d_pos", ch));
    bus_read(ch, 1, {30'd0, m_dir[ch], m_err[ch]}, $sformatf("ch%0d_stat", ch));
    bus_read(ch, 2, 32'(m_per[ch]), $sformatf("ch%0d_period", ch));
    bus_read(ch, 3, 32'(m_duty[ch]), $sformatf("ch%0d_duty", ch));
  endtask

  always @(posedge clk) rd_seen <= rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_read: got %0h with nothing expected", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (rdata !== mon_e) begin
          mismatched++;
          $display("FAIL %s: got %0h expected %0h", mon_n, rdata, mon_e);
        end
      end
    end
  end

  task automatic pwm_window(input string nm, input logic expv, input int n);
    for (int k = 0; k < n; k++) begin
      chk(nm, 32'(pwm[0]), 32'(expv));
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; enc = '0; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
    model_reset();
    cycles(4);
    rst = 1'b0;
    cycles(1);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    read_model(0);
    read_model(1);

    // Three forward cycles then three reverse cycles on ch0
    for (int s = 0; s < 12; s++) begin step(0, 1'b1); cycles(4); end
    cycles(SETTLE);
    bus_read(0, 0, 32'd12, "fwd_pos");
    bus_read(0, 1, 32'd2, "fwd_stat");
    for (int s = 0; s < 12; s++) begin step(0, 1'b0); cycles(4); end
    cycles(SETTLE);
    bus_read(0, 0, 32'd0, "rev_pos");
    bus_read(0, 1, 32'd0, "rev_stat");
    bus_read(1, 0, 32'd0, "ch1_untouched");

    // Wrap-around in both directions, then a write colliding with a step
    bus_write(0, 0, 32'h0000_FFFF);
    step(0, 1'b1); cycles(SETTLE);
    bus_read(0, 0, 32'd0, "wrap_up");
    step(0, 1'b0); cycles(SETTLE);
    bus_read(0, 0, 32'h0000_FFFF, "wrap_down");
    step(0, 1'b1);
    cycles(LAT - 1);
    bus_write(0, 0, 32'd5);
    cycles(SETTLE);
    bus_read(0, 0, 32'd5, "write_beats_step");

    // Decode latency: old value on edge LAT, new value one edge later
    step(0, 1'b1);
    cycles(LAT - 1);
    bus_read(0, 0, 32'd5, "latency_before");
    bus_read(0, 0, 32'd6, "latency_after");
    cycles(SETTLE);

    // Illegal transitions and sticky error on ch1
    set_pins(1, 2'b11); cycles(SETTLE);
    read_model(1);
    bus_write(1, 1, 32'd1); cycles(2);
    bus_read(1, 1, 32'd0, "err_cleared");
    set_pins(1, 2'b00);
    cycles(LAT - 1);
    bus_write(1, 1, 32'd1);
    m_err[1] = 1'b1;  // illegal step in the clearing cycle keeps the flag
    cycles(SETTLE);
    bus_read(1, 1, 32'd1, "err_clear_collision");
    bus_read(1, 0, 32'd0, "err_pos_hold");

    // Short pulse on ch0 A
    bus_write(0, 1, 32'd1);
`ifdef QUAD_ENC_GLITCH_FILTER_EN
    enc[0] = ~enc[0]; cycles(2); enc[0] = ~enc[0];
`else
    set_pins(0, m_ab[0] ^ 2'b10); cycles(1); set_pins(0, m_ab[0] ^ 2'b10);
`endif
    cycles(SETTLE);
    read_model(0);

    // Randomised walk with occasional illegal steps and position loads
    for (int it = 0; it < 48; it++) begin
      int ch;
      int sel;
      ch  = $urandom_range(0, NUM_CH - 1);
      sel = $urandom_range(0, 9);
      if (sel == 0) set_pins(ch, m_ab[ch] ^ 2'b11);
      else if (sel == 1) begin cycles(SETTLE); bus_write(ch, 0, $urandom); end
      else step(ch, $urandom_range(0, 1) == 1);
      cycles($urandom_range(4, 7));
      if (it % 8 == 7) begin
        cycles(SETTLE);
        for (int c = 0; c < NUM_CH; c++) read_model(c);
      end
    end

    // PWM on ch0: period 10, duty 3, then a mid-period duty change
    bus_write(0, 2, 32'd9);
    bus_write(0, 3, 32'd3);
    read_model(0);
    found = 1'b0;
    for (int t = 0; t < 2200; t++) begin
      if (pwm[0]) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("pwm_first_rise", 32'(found), 32'd1);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("pwm_cycle%0d", k), 32'(pwm[0]),
          32'((k < 10) ? ((k % 10) < 3) : ((k % 10) < 7)));
      if (k % 5 == 0) chk("pwm_ch1_idle", 32'(pwm[1]), 32'd0);
      if (k == 4) begin addr = 3'd3; wdata = 32'd7; wr = 1'b1; end
      if (k == 5) wr = 1'b0;
      @(negedge clk);
    end
    m_duty[0] = 7;
    bus_write(0, 3, 32'd0);  cycles(25); pwm_window("pwm_duty0", 1'b0, 20);
    bus_write(0, 3, 32'd15); cycles(25); pwm_window("pwm_duty_over", 1'b1, 20);
    bus_write(0, 2, 32'd0);
    bus_write(0, 3, 32'd1);  cycles(25); pwm_window("pwm_period0_on", 1'b1, 10);
    bus_write(0, 3, 32'd0);  cycles(5);  pwm_window("pwm_period0_off", 1'b0, 10);
    bus_write(0, 3, 32'd15); cycles(5);
    read_model(0);

    // Reset in the middle of activity
    enc = '0;
    rst = 1'b1; cycles(2); rst = 1'b0;
    model_reset();
    cycles(1);
    chk("midreset_pwm", 32'(pwm), 32'd0);
    read_model(0);
    read_model(1);

    cycles(4);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
